input_debouncer: RTL and testbench

Conditions the raw, asynchronous pushbutton/serial bit that feeds the mod-3 Mealy counter stage.
- Synchronizes the raw input into clk.
- Filters bounce with a symmetric stability counter.
- Emits a clean debounced level and a single-cycle rising-edge pulse.
- The pulse drives the counter's `in`, so one physical press gives exactly one counted event.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/sync_chain.sv | 30 +++
 rtl/input_debouncer.sv | 130 +++++++++++++
 tb/tb_input_debouncer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared debounce constants: FSM state encodings and default filter sizing.
// No logic; imported by input_debouncer and other input-conditioning stages.
// No flow control.
package debounce_pkg;

    localparam logic [1:0] S_LOW      = 2'b00;
    localparam logic [1:0] S_RISE_CHK = 2'b01;
    localparam logic [1:0] S_HIGH     = 2'b10;
    localparam logic [1:0] S_FALL_CHK = 2'b11;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit into clk.
// Latency: STAGES clk edges from d to q.
// No flow control; samples every edge.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw button bit; emits clean level and one-cycle edge pulses (fall_pulse only with FALL_PULSE_EN).
// Latency: SYNC_STAGES+STABLE_CYCLES clk edges from a stable raw change to level/pulse.
// No backpressure; pulses are single-cycle and never back-to-back.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic pulse
`ifdef FALL_PULSE_EN
    ,
    output logic fall_pulse
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
`ifdef FALL_PULSE_EN
    logic             fall_pulse_q, fall_pulse_d;
`endif

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (sync_q)
    );

    // Any reversal inside a check state falls back to the stable state and restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
`ifdef FALL_PULSE_EN
        fall_pulse_d = 1'b0;
`endif
        case (state_q)
            S_LOW: begin
                if (sync_q) begin
                    state_d = S_RISE_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_RISE_CHK: begin
                if (!sync_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync_q) begin
                    state_d = S_FALL_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_FALL_CHK: begin
                if (sync_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    level_d = 1'b0;
`ifdef FALL_PULSE_EN
                    fall_pulse_d = 1'b1;
`endif
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
`ifdef FALL_PULSE_EN
            fall_pulse_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
`ifdef FALL_PULSE_EN
            fall_pulse_q <= fall_pulse_d;
`endif
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;
`ifdef FALL_PULSE_EN
    assign fall_pulse = fall_pulse_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: run-length reference model checked every cycle plus literal scenario expectations.
module tb_input_debouncer;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int LAT           = SYNC_STAGES + STABLE_CYCLES;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw = 1'b0;
    logic level;
    logic pulse;
`ifdef FALL_PULSE_EN
    logic fall_pulse;
`endif

    int total  = 0;
    int passed = 0;

    input_debouncer #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .level   (level),
        .pulse   (pulse)
`ifdef FALL_PULSE_EN
        ,
        .fall_pulse (fall_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: the filter sees raw delayed by SYNC_STAGES edges, and the
    // level flips once STABLE_CYCLES consecutive samples disagree with it.
    bit m_hist [SYNC_STAGES];
    bit m_level = 1'b0;
    bit m_pulse = 1'b0;
    bit m_fall  = 1'b0;
    bit m_s;
    int m_run   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
            m_level = 1'b0;
            m_pulse = 1'b0;
            m_fall  = 1'b0;
            m_run   = 0;
        end else begin
            m_s = m_hist[SYNC_STAGES-1];
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = btn_raw;
            m_pulse = 1'b0;
            m_fall  = 1'b0;
            if (m_s != m_level) begin
                m_run++;
                if (m_run == STABLE_CYCLES) begin
                    m_level = m_s;
                    m_pulse = m_s;
                    m_fall  = !m_s;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // Mod-3 counter stage fed by pulse.
    int m3 = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) m3 <= 0;
        else if (pulse) m3 <= (m3 + 1) % 3;
    end

    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        chk("model_level", int'(level), int'(m_level));
        chk("model_pulse", int'(pulse), int'(m_pulse));
        if (prev_pulse) chk("pulse_not_back_to_back", int'(pulse), 0);
        prev_pulse = pulse;
`ifdef FALL_PULSE_EN
        chk("model_fall_pulse", int'(fall_pulse), int'(m_fall));
`endif
    end

    // Drive btn_raw now and observe n edges; first_* = edge index (1-based) of first pulse, -1 if none.
    task automatic hold(input logic b, input int n, output int np, output int first_p,
                        output int nf, output int first_f);
        np = 0; first_p = -1; nf = 0; first_f = -1;
        btn_raw = b;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (pulse) begin
                np++;
                if (first_p < 0) first_p = i;
            end
`ifdef FALL_PULSE_EN
            if (fall_pulse) begin
                nf++;
                if (first_f < 0) first_f = i;
            end
`endif
        end
    endtask

    int np, fp, nf, ff, acc, m3_start;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_level", int'(level), 0);
        chk("reset_pulse", int'(pulse), 0);
`ifdef FALL_PULSE_EN
        chk("reset_fall_pulse", int'(fall_pulse), 0);
`endif
        rst = 1'b0;

        // Clean rise held 20 cycles
        hold(1'b1, 20, np, fp, nf, ff);
        chk("rise_pulse_count", np, 1);
        chk("rise_pulse_edge", fp, LAT);
        chk("rise_level", int'(level), 1);

        // Clean fall
        hold(1'b0, 20, np, fp, nf, ff);
        chk("fall_no_rise_pulse", np, 0);
        chk("fall_level", int'(level), 0);
`ifdef FALL_PULSE_EN
        chk("fall_pulse_count", nf, 1);
        chk("fall_pulse_edge", ff, LAT);
`endif

        // Short 2-cycle glitch rejected
        hold(1'b1, 2, np, fp, nf, ff);
        acc = np;
        hold(1'b0, 12, np, fp, nf, ff);
        acc += np;
        chk("glitch_no_pulse", acc, 0);
        chk("glitch_level", int'(level), 0);

        // Bounce 1,0,1,0 then steady 1
        acc = 0;
        hold(1'b1, 1, np, fp, nf, ff); acc += np;
        hold(1'b0, 1, np, fp, nf, ff); acc += np;
        hold(1'b1, 1, np, fp, nf, ff); acc += np;
        hold(1'b0, 1, np, fp, nf, ff); acc += np;
        chk("bounce_no_pulse", acc, 0);
        hold(1'b1, 20, np, fp, nf, ff);
        chk("bounce_pulse_count", np, 1);
        chk("bounce_pulse_edge", fp, LAT);
        hold(1'b0, 20, np, fp, nf, ff);
        chk("bounce_return_low", int'(level), 0);

        // Reset during rise check, then release with button held
        hold(1'b1, 5, np, fp, nf, ff);
        chk("midchk_no_pulse_yet", np, 0);
        #2 rst = 1'b1;
        #1;
        chk("midchk_rst_level", int'(level), 0);
        chk("midchk_rst_pulse", int'(pulse), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        hold(1'b1, 20, np, fp, nf, ff);
        chk("post_rst_pulse_count", np, 1);
        chk("post_rst_pulse_edge", fp, LAT);
        hold(1'b0, 20, np, fp, nf, ff);

        // Three clean presses into the mod-3 counter
        m3_start = m3;
        acc = 0;
        for (int k = 0; k < 3; k++) begin
            hold(1'b1, 10, np, fp, nf, ff); acc += np;
            hold(1'b0, 10, np, fp, nf, ff); acc += np;
        end
        chk("three_press_pulses", acc, 3);
        chk("mod3_returns", m3, m3_start);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
